// File: rtl/sram_arbiter_if.sv
// Requester-side handshake and SRAM pin-driver bus shared by the three effect ports.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM model/pins.
interface sram_arbiter_if;
  logic [2:0]  i_req;
  logic [2:0]  i_we;
  logic [59:0] i_addr;
  logic [47:0] i_wdata;
  logic [2:0]  o_ack;
  logic        o_err;
  logic [15:0] o_rdata;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n;
  logic [15:0] o_sram_wdata;
  logic [15:0] i_sram_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_sram_rdata,
    output o_ack, o_err, o_rdata, o_sram_addr, o_sram_we_n, o_sram_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_sram_rdata,
    input  o_ack, o_err, o_rdata, o_sram_addr, o_sram_we_n, o_sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 16-bit SRAM between three windowed requesters.
// One access in flight; all outputs registered from next-state values.
module sram_arbiter #(
  parameter int unsigned READ_WAIT = 2,
  parameter int          P0_LO     = 0,
  parameter int          P0_HI     = 351999,
  parameter int          P1_LO     = 352000,
  parameter int          P1_HI     = 671999,
  parameter int          P2_LO     = 672000,
  parameter int          P2_HI     = 1048575
) (
  input logic           i_clk,
  input logic           i_rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [2:0]  ack_q, ack_d;
  logic        oerr_q, oerr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic [15:0] sram_wdata_q, sram_wdata_d;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [19:0] win_addr;
  logic [15:0] win_wdata;

  function automatic logic in_window(input logic [1:0] p, input logic [19:0] a);
    int ai;
    ai = int'({12'b0, a});
    case (p)
      2'd0:    return (ai >= P0_LO) && (ai <= P0_HI);
      2'd1:    return (ai >= P1_LO) && (ai <= P1_HI);
      2'd2:    return (ai >= P2_LO) && (ai <= P2_HI);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = 2'((32'(rr_ptr_q) + i) % 3);
      if (!win_vld && bus.i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_addr  = bus.i_addr[20*win_idx +: 20];
  assign win_wdata = bus.i_wdata[16*win_idx +: 16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
      ack_q        <= '0;
      oerr_q       <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_we_n_q  <= 1'b1;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
      ack_q        <= ack_d;
      oerr_q       <= oerr_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // The window check uses the winner's address in the grant cycle so the
  // registered SRAM strobes can already be correct one cycle later.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d      = win_idx;
          we_d       = bus.i_we[win_idx];
          addr_d     = win_addr;
          wdata_d    = win_wdata;
          err_d      = !in_window(win_idx, win_addr);
          wait_cnt_d = '0;
          if (err_d)     state_d = S_DONE;
          else if (we_d) state_d = S_WRITE;
          else           state_d = S_READ;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_READ: begin
        if (wait_cnt_q == 8'(READ_WAIT - 1)) state_d = S_DONE;
        else                                 wait_cnt_d = wait_cnt_q + 8'd1;
      end
      S_DONE: begin
        rr_ptr_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d        = '0;
    oerr_d       = 1'b0;
    rdata_d      = rdata_q;
    sram_addr_d  = '0;
    sram_we_n_d  = 1'b1;
    sram_wdata_d = '0;
    if (state_d == S_DONE) begin
      ack_d[idx_d] = 1'b1;
      oerr_d       = err_d;
    end
    if (state_q == S_READ && state_d == S_DONE) rdata_d = bus.i_sram_rdata;
    if (state_d == S_WRITE || state_d == S_READ) sram_addr_d = addr_d;
    if (state_d == S_WRITE) begin
      sram_we_n_d  = 1'b0;
      sram_wdata_d = wdata_d;
    end
  end

  assign bus.o_ack        = ack_q;
  assign bus.o_err        = oerr_q;
  assign bus.o_rdata      = rdata_q;
  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_we_n  = sram_we_n_q;
  assign bus.o_sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default READ_WAIT instance plus a READ_WAIT=4 instance.
module tb_sram_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_idx;

  sram_arbiter_if bus_a ();
  sram_arbiter_if bus_b ();

  sram_arbiter dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  sram_arbiter #(.READ_WAIT(4)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  // Small SRAM model for the default instance: fixed contents at two addresses.
  assign bus_a.i_sram_rdata = (bus_a.o_sram_addr == 20'd500)    ? 16'hBEEF :
                              (bus_a.o_sram_addr == 20'd352000) ? 16'h5A5A : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] cont_addr [3];
    checks = 0;
    errors = 0;
    cont_addr[0] = 20'd20;
    cont_addr[1] = 20'd400000;
    cont_addr[2] = 20'd700000;
    rst = 1'b1;
    bus_a.i_req = '0; bus_a.i_we = '0; bus_a.i_addr = '0; bus_a.i_wdata = '0;
    bus_b.i_req = '0; bus_b.i_we = '0; bus_b.i_addr = '0; bus_b.i_wdata = '0;
    bus_b.i_sram_rdata = '0;
    step(); step();
    chk("rst_ack",   32'(bus_a.o_ack), 32'h0);
    chk("rst_err",   32'(bus_a.o_err), 32'h0);
    chk("rst_rdata", 32'(bus_a.o_rdata), 32'h0);
    chk("rst_addr",  32'(bus_a.o_sram_addr), 32'h0);
    chk("rst_we_n",  32'(bus_a.o_sram_we_n), 32'h1);
    chk("rst_wdata", 32'(bus_a.o_sram_wdata), 32'h0);
    chk("rst_b_we_n", 32'(bus_b.o_sram_we_n), 32'h1);

    // Single write, port 1
    rst = 1'b0;
    bus_a.i_req = 3'b010; bus_a.i_we = 3'b010;
    bus_a.i_addr[39:20] = 20'd352000; bus_a.i_wdata[31:16] = 16'h1234;
    step();
    chk("wr_we_n",  32'(bus_a.o_sram_we_n), 32'h0);
    chk("wr_addr",  32'(bus_a.o_sram_addr), 32'd352000);
    chk("wr_wdata", 32'(bus_a.o_sram_wdata), 32'h1234);
    chk("wr_noack", 32'(bus_a.o_ack), 32'h0);
    step();
    chk("wr_ack",   32'(bus_a.o_ack), 32'h2);
    chk("wr_err",   32'(bus_a.o_err), 32'h0);
    chk("wr_done_we_n", 32'(bus_a.o_sram_we_n), 32'h1);
    bus_a.i_req = '0;
    step();
    chk("wr_ack_pulse", 32'(bus_a.o_ack), 32'h0);

    // Single read, port 0 at 500
    bus_a.i_req = 3'b001; bus_a.i_we = 3'b000; bus_a.i_addr[19:0] = 20'd500;
    step();
    chk("rd_addr1", 32'(bus_a.o_sram_addr), 32'd500);
    chk("rd_we_n1", 32'(bus_a.o_sram_we_n), 32'h1);
    step();
    chk("rd_addr2", 32'(bus_a.o_sram_addr), 32'd500);
    chk("rd_noack", 32'(bus_a.o_ack), 32'h0);
    step();
    chk("rd_ack",   32'(bus_a.o_ack), 32'h1);
    chk("rd_data",  32'(bus_a.o_rdata), 32'hBEEF);
    chk("rd_idle_addr", 32'(bus_a.o_sram_addr), 32'h0);
    bus_a.i_req = '0;
    step();

    // Window bounds on port 1
    bus_a.i_req = 3'b010; bus_a.i_we = 3'b010; bus_a.i_addr[39:20] = 20'd351999;
    step();
    chk("lo_m1_ack",  32'(bus_a.o_ack), 32'h2);
    chk("lo_m1_err",  32'(bus_a.o_err), 32'h1);
    chk("lo_m1_we_n", 32'(bus_a.o_sram_we_n), 32'h1);
    chk("lo_m1_rdata", 32'(bus_a.o_rdata), 32'hBEEF);
    bus_a.i_req = '0;
    step();
    bus_a.i_req = 3'b010; bus_a.i_we = 3'b000; bus_a.i_addr[39:20] = 20'd672000;
    step();
    chk("hi_p1_ack",  32'(bus_a.o_ack), 32'h2);
    chk("hi_p1_err",  32'(bus_a.o_err), 32'h1);
    chk("hi_p1_addr", 32'(bus_a.o_sram_addr), 32'h0);
    chk("hi_p1_rdata", 32'(bus_a.o_rdata), 32'hBEEF);
    bus_a.i_req = '0;
    step();
    bus_a.i_req = 3'b010; bus_a.i_we = 3'b010;
    bus_a.i_addr[39:20] = 20'd671999; bus_a.i_wdata[31:16] = 16'hABCD;
    step();
    chk("hi_we_n", 32'(bus_a.o_sram_we_n), 32'h0);
    chk("hi_addr", 32'(bus_a.o_sram_addr), 32'd671999);
    step();
    chk("hi_ack", 32'(bus_a.o_ack), 32'h2);
    chk("hi_err", 32'(bus_a.o_err), 32'h0);
    bus_a.i_req = '0;
    step();
    bus_a.i_req = 3'b010; bus_a.i_we = 3'b000; bus_a.i_addr[39:20] = 20'd352000;
    step(); step(); step();
    chk("lo_rd_ack",   32'(bus_a.o_ack), 32'h2);
    chk("lo_rd_err",   32'(bus_a.o_err), 32'h0);
    chk("lo_rd_rdata", 32'(bus_a.o_rdata), 32'h5A5A);
    bus_a.i_req = '0;
    step();

    // Reset in the middle of a write
    bus_a.i_req = 3'b001; bus_a.i_we = 3'b001;
    bus_a.i_addr[19:0] = 20'd10; bus_a.i_wdata[15:0] = 16'h5555;
    step();
    chk("mid_we_n", 32'(bus_a.o_sram_we_n), 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we_n",  32'(bus_a.o_sram_we_n), 32'h1);
    chk("mid_rst_addr",  32'(bus_a.o_sram_addr), 32'h0);
    chk("mid_rst_wdata", 32'(bus_a.o_sram_wdata), 32'h0);
    chk("mid_rst_ack",   32'(bus_a.o_ack), 32'h0);
    chk("mid_rst_rdata", 32'(bus_a.o_rdata), 32'h0);
    bus_a.i_req = 3'b101; bus_a.i_we = 3'b111;
    bus_a.i_addr[19:0] = 20'd20;      bus_a.i_wdata[15:0]  = 16'h1111;
    bus_a.i_addr[39:20] = 20'd400000; bus_a.i_wdata[31:16] = 16'h3333;
    bus_a.i_addr[59:40] = 20'd700000; bus_a.i_wdata[47:32] = 16'h2222;
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("post_rst_addr", 32'(bus_a.o_sram_addr), 32'd20);
    chk("post_rst_we_n", 32'(bus_a.o_sram_we_n), 32'h0);
    step();
    chk("post_rst_ack0", 32'(bus_a.o_ack), 32'h1);
    bus_a.i_req[0] = 1'b0;
    step();
    chk("post_rst_gap", 32'(bus_a.o_ack), 32'h0);
    step();
    chk("p2_addr",  32'(bus_a.o_sram_addr), 32'd700000);
    chk("p2_wdata", 32'(bus_a.o_sram_wdata), 32'h2222);
    step();
    chk("p2_ack", 32'(bus_a.o_ack), 32'h4);
    bus_a.i_req = 3'b111;

    // Continuous contention: order must be 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      exp_idx = k % 3;
      step();
      chk("cont_idle", 32'(bus_a.o_ack), 32'h0);
      step();
      chk("cont_addr", 32'(bus_a.o_sram_addr), 32'(cont_addr[exp_idx]));
      step();
      chk("cont_ack", 32'(bus_a.o_ack), 32'h1 << exp_idx);
    end
    bus_a.i_req = '0;

    // READ_WAIT=4 instance, port 2 read at 700000
    bus_b.i_req = 3'b100; bus_b.i_we = 3'b000; bus_b.i_addr[59:40] = 20'd700000;
    bus_b.i_sram_rdata = 16'hDEAD;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("rw4_addr",  32'(bus_b.o_sram_addr), 32'd700000);
      chk("rw4_we_n",  32'(bus_b.o_sram_we_n), 32'h1);
      chk("rw4_noack", 32'(bus_b.o_ack), 32'h0);
      if (c == 4) bus_b.i_sram_rdata = 16'hC0DE;
    end
    step();
    chk("rw4_ack",   32'(bus_b.o_ack), 32'h4);
    chk("rw4_rdata", 32'(bus_b.o_rdata), 32'hC0DE);
    chk("rw4_err",   32'(bus_b.o_err), 32'h0);
    chk("rw4_idle_addr", 32'(bus_b.o_sram_addr), 32'h0);
    bus_b.i_sram_rdata = 16'hBAD0;
    bus_b.i_req = '0;
    step();
    chk("rw4_ack_pulse", 32'(bus_b.o_ack), 32'h0);
    chk("rw4_rdata_hold", 32'(bus_b.o_rdata), 32'hC0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 16-bit SRAM between three effect-chain requesters: port 0 delay/echo, port 1 loop effect, port 2 raw recorder. Each port issues one word read or write through a level-request/pulse-ack handshake. Arbitration is round-robin, and at most one SRAM access is in flight. Each port is confined to a fixed address window; violating requests never reach the SRAM. The block sits between the effect modules and the top-level SRAM pin driver.

## Interface
Parameters:
- READ_WAIT, 2: cycles the read address is held before data is latched (≥1).
- P0_LO, 0 / P0_HI, 351999: port 0 inclusive address window.
- P1_LO, 352000 / P1_HI, 671999: port 1 window.
- P2_LO, 672000 / P2_HI, 1048575: port 2 window.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  3  per-port request level; bit k is port k.
- i_we  in  3  per-port direction: 1 = write, 0 = read.
- i_addr  in  60  per-port word address; port k uses bits [20k+19:20k].
- i_wdata  in  48  per-port write data; port k uses bits [16k+15:16k].
- o_ack  out  3  one-cycle completion pulse for the granted port.
- o_err  out  1  pulses with o_ack when the request was out of window.
- o_rdata  out  16  read data; valid during o_ack of a read and held until the next read completes.
- o_sram_addr  out  20  SRAM address.
- o_sram_we_n  out  1  SRAM write enable, active low.
- o_sram_wdata  out  16  SRAM write data.
- i_sram_rdata  in  16  SRAM read data.

## Operation
- States: S_IDLE, S_WRITE, S_READ, S_DONE.
- S_IDLE:
  - If any i_req bit is high, choose the winner by round-robin, searching from rr_ptr upward modulo 3.
  - Latch the winner's index, we, addr and wdata. Requester inputs are don't-care after this grant cycle.
  - Window check on the latched address: if it is out of window, go to S_DONE with err=1. Otherwise go to S_WRITE when we=1, or S_READ when we=0.
- S_WRITE: drive addr and wdata with we_n=0 for exactly one cycle, then go to S_DONE.
- S_READ:
  - Drive addr with we_n=1 for READ_WAIT cycles, counted by wait_cnt.
  - On the last cycle, register i_sram_rdata into o_rdata, then go to S_DONE.
- S_DONE:
  - o_ack[idx]=1 and o_err=err.
  - Drive the SRAM bus to its idle values.
  - rr_ptr ← (idx+1) mod 3, then return to S_IDLE.
- Outside S_WRITE and S_READ the SRAM bus is idle: o_sram_addr=0, o_sram_we_n=1, o_sram_wdata=0.
- Handshake rules:
  - A requester holds i_req high until it sees o_ack.
  - It must drop i_req (or present a new request) in the cycle after o_ack.
  - i_req is sampled only in S_IDLE. A request cannot be withdrawn once granted.
- Window check is inclusive: LO ≤ addr ≤ HI. Address LO-1 or HI+1 is an error.
- Error completions do not modify o_rdata and do not toggle o_sram_we_n.
- o_rdata is never cleared except by reset.

## Timing
- Cycle t is the cycle in which S_IDLE sees i_req high (the grant cycle).
- Write: o_sram_we_n=0 at t+1; o_ack at t+2. Back-to-back writes reach one every 3 cycles.
- Read: address driven t+1 … t+READ_WAIT; data latched at the end of cycle t+READ_WAIT; o_ack with valid o_rdata at t+READ_WAIT+1. With the default, ack is at t+3.
- Error: o_ack and o_err at t+1; no SRAM cycle.
- Simultaneous requests: exactly one grant per S_IDLE visit. Worst-case wait for any port is two other accesses.
- A request arriving while busy waits; it is evaluated at the next S_IDLE.
- Registered outputs: o_ack, o_err, o_rdata, and all SRAM outputs are registered. No combinational path from i_req to any output.
- Reset: asserting i_rst at any point, including mid-S_WRITE, immediately forces:
  - state=S_IDLE, rr_ptr=0, wait_cnt=0;
  - o_ack=0, o_err=0, o_rdata=0;
  - o_sram_addr=0, o_sram_we_n=1, o_sram_wdata=0.
  
  An interrupted access is lost; requesters reissue. The first grant after reset favours port 0.

## Test plan
- Single write: port 1 req, we=1, addr 352000, wdata 0x1234 → o_sram_we_n=0 with addr 352000 / data 0x1234 one cycle after grant; o_ack=3'b010 two cycles after grant; o_err=0.
- Single read: preload SRAM model 0xBEEF at 500, then port 0 reads addr 500 → addr 500 held 2 cycles with we_n=1; o_ack=3'b001 with o_rdata=0xBEEF 3 cycles after grant.
- Contention: all three req high continuously, each acking then reissuing → grant order 0,1,2,0,1,2; no port ever waits more than two accesses.
- Window bounds: port 1 at 351999 and at 672000 → o_ack+o_err one cycle after grant, we_n stays 1. Port 1 at 352000 and at 671999 → normal access, o_err=0.
- Reset mid-write: assert i_rst during S_WRITE → o_sram_we_n=1 in the same cycle, all outputs at reset values. After release, port 2 and port 0 requesting together → port 0 granted first.
- Wait parameter: READ_WAIT=4, port 2 reads addr 700000 → address held 4 cycles; ack 5 cycles after grant with the data present at the end of the fourth cycle.
